// File: rtl/load_store_controller.sv
// load_store_controller: sequences one data-memory load/store at a time with lane steering, extension and error/timeout reporting.
module load_store_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       size_q, size_d, lane_q, lane_d;
  logic             uns_q, uns_d, mem_we_q, mem_we_d, resp_err_q, resp_err_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             bad_req;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  always_comb begin
    bad_req  = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]);
    st_be    = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
               req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_wdata = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
               req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    ld_data  = size_q == 2'b00 ? {{24{~uns_q & ld_byte[7]}}, ld_byte} :
               size_q == 2'b01 ? {{16{~uns_q & ld_half[15]}}, ld_half} : mem_rdata;
  end
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    lane_d       = lane_q;
    uns_d        = uns_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (bad_req) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d     = ISSUE;
          size_d      = req_size;
          lane_d      = req_addr[1:0];
          uns_d       = req_unsigned;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = req_we ? st_be : 4'b1111;
          mem_wdata_d = req_we ? st_wdata : '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (mem_ready) begin
        state_d      = RESP;
        resp_err_d   = 1'b0;
        resp_rdata_d = mem_we_q ? '0 : ld_data;
      end else if (TIMEOUT != 0) begin
        // the counter value names the current WAIT cycle, so expiry at TIMEOUT-1 yields TIMEOUT cycles
        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      lane_q       <= '0;
      uns_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      uns_q        <= uns_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end
  assign req_ready  = (state_q == IDLE) & ~reset;
  assign mem_en     = state_q == ISSUE;
  assign resp_valid = state_q == RESP;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_controller.sv
// tb_load_store_controller: directed vectors checked every cycle against a timeline/arithmetic model of the controller.
module tb_load_store_controller;
  localparam int TO = 8;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, mem_ready = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_en, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0, errors = 0, cyc = 0;
  int exp_en = -1, exp_resp = -1, hold_end = -1;
  logic active = 1'b0;
  logic        e_we, e_err;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wd, e_rd;

  load_store_controller #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd2) return rd;
    if (sz == 2'd0) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  always @(negedge clk) if (active) begin
    chk("mem_en", {31'b0, mem_en}, {31'b0, cyc == exp_en});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == exp_resp});
    if (exp_en >= 0 && cyc >= exp_en && cyc < hold_end) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    end
    if (cyc == exp_resp) begin
      chk("resp_rdata", resp_rdata, e_rd);
      chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
    end
  end

  // d = index of the WAIT cycle in which mem_ready is raised; d >= TO means it never arrives in time
  task automatic run(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int d,
                     input logic [31:0] lit_rd, input logic lit_err);
    int t, n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    t = cyc;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    e_we = we;
    e_addr = a & ~32'd3;
    e_be = !we || sz == 2'd2 ? 4'hF : sz == 2'd0 ? 4'(1 << (a % 4)) : 4'(3 << (a & 2));
    e_wd = sz == 2'd0 ? (wd & 32'hFF) * 32'h01010101 : sz == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    e_err = sz == 2'd3 || (a % (32'd1 << sz)) != 0;
    if (e_err) begin
      e_rd = 0; exp_en = -1; exp_resp = t + 1;
    end else begin
      exp_en = t + 1;
      exp_resp = d < TO ? t + 3 + d : t + 2 + TO;
      e_err = d >= TO;
      e_rd = (we || e_err) ? 32'd0 : ld_model(sz, uns, a, rd);
    end
    hold_end = exp_resp;
    @(negedge clk);
    req_valid = 1'b0;
    mem_rdata = rd;
    if (exp_en >= 0) begin
      while (cyc < (d < TO ? t + 2 + d : exp_resp)) @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      if (d >= TO) @(negedge clk);
      mem_ready = 1'b0;
    end
    while (cyc < exp_resp + 1) @(negedge clk);
    chk("resp_rdata_held", resp_rdata, lit_rd);
    chk("resp_err_held", {31'b0, resp_err}, {31'b0, lit_err});
    exp_en = -1; exp_resp = -1; hold_end = -1;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    active = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    run(1, 2'd0, 0, 32'h103, 32'h000000AB, 32'h0, 0, 32'h0, 0);
    run(0, 2'd0, 0, 32'h102, 32'h0, 32'h12F03456, 1, 32'hFFFFFFF0, 0);
    run(0, 2'd0, 1, 32'h102, 32'h0, 32'h12F03456, 0, 32'h000000F0, 0);
    run(0, 2'd1, 0, 32'h2, 32'h0, 32'h80017FFF, 0, 32'hFFFF8001, 0);
    run(0, 2'd1, 0, 32'h0, 32'h0, 32'h80017FFF, 2, 32'h00007FFF, 0);
    run(0, 2'd2, 0, 32'h4, 32'h0, 32'h80017FFF, 0, 32'h80017FFF, 0);
    run(1, 2'd1, 0, 32'h22, 32'hDEAD1234, 32'h0, 1, 32'h0, 0);
    run(1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 32'h0, 0);
    run(0, 2'd0, 0, 32'h201, 32'h0, 32'h00008500, 3, 32'hFFFFFF85, 0);
    run(0, 2'd2, 0, 32'h6, 32'h0, 32'h0, 0, 32'h0, 1);
    run(0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1);
    run(0, 2'd1, 0, 32'h1, 32'h0, 32'h0, 0, 32'h0, 1);
    run(0, 2'd2, 0, 32'h8, 32'h0, 32'h11223344, TO, 32'h0, 1);
    run(0, 2'd2, 0, 32'hC, 32'h0, 32'h55667788, TO - 1, 32'h55667788, 0);
    @(negedge clk);
    t = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    e_we = 1'b0; e_addr = 32'h10; e_be = 4'hF;
    exp_en = t + 1; exp_resp = -1; hold_end = t + 4;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_en = -1; hold_end = -1;
    @(negedge clk);
    chk("rst_exit_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    run(0, 2'd1, 1, 32'h12, 32'h0, 32'hBEEF0000, 1, 32'h0000BEEF, 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
Sequences every data-memory access issued by the execute stage. Accepts one load/store request at a time and drives the word-wide data memory with byte enables and lane-replicated write data. Waits for the memory handshake, then extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits. Detects misaligned or illegal-size requests and memory timeouts, and reports both as errors.

Parameters:
TIMEOUT, 16, max WAIT cycles without mem_ready before error; 0 disables timeout
CNT_W, 16, width of timeout counter; TIMEOUT must fit in CNT_W bits

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1; ignored for word and stores
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse, no backpressure
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid; misalign, illegal size or timeout
mem_en  output  1  one-cycle access strobe
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  32  word address {req_addr[31:2],2'b00}
mem_be  output  4  byte enables, bit k = bits [8k+7:8k]
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read word, valid when mem_ready is high
mem_ready  input  1  access complete; earliest one cycle after mem_en

Behaviour:
- Reset (synchronous, checked at the clock edge): state=IDLE, counter=0, all registered outputs 0. req_ready is 0 while reset is high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is also high, latch the request, then:
  - error check: size 11, or half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1 and no memory access;
  - otherwise -> ISSUE.
- ISSUE: mem_en=1 for exactly one cycle; mem_we/mem_addr/mem_be/mem_wdata valid; clear counter; -> WAIT.
- WAIT: mem_en=0; mem_addr/mem_we/mem_be/mem_wdata held stable.
  - mem_ready=1: capture the extracted load data -> RESP, err=0.
  - mem_ready=0 with TIMEOUT!=0: counter increments; when counter reaches TIMEOUT-1 with no ready -> RESP, err=1. This gives exactly TIMEOUT WAIT cycles.
  - If mem_ready arrives in the same cycle the timeout expires, ready wins (no error).
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_err; -> IDLE. resp_rdata/resp_err hold their values until the next response.
- mem_ready is ignored outside WAIT, so a late ready after a timeout has no effect.
- Minimum latency: accept at cycle T, mem_en at T+1, ready at T+2, resp_valid at T+3. Error path: resp_valid at T+1.
- A new request can be accepted in the cycle after RESP, giving a 4-cycle throughput floor.
- Store lanes (little-endian, k = addr[1:0]):
  - byte: be = 1<<k, wdata = {4{wdata[7:0]}};
  - half: be = 0011 (addr[1]=0) or 1100, wdata = {2{wdata[15:0]}};
  - word: be = 1111, wdata unchanged.
- Loads: mem_we=0, mem_be=1111.
  - byte: take lane k, replicate bit 7 into bits 31:8, or 0 if req_unsigned;
  - half: take lane addr[1], same rule using bit 15;
  - word: pass through.
- Stores return resp_rdata=0.
- Reset asserted in any state abandons the access: no resp_valid, mem_en=0 from the next cycle, req_ready=1 in the first cycle after reset deasserts.

Test Plan:
- Store byte, addr 0x103, wdata 0x000000AB -> mem_addr 0x100, mem_be 1000, mem_wdata 0xABABABAB, mem_we 1; resp_valid 1, rdata 0, err 0.
- Load byte, addr 0x102, mem_rdata 0x12F03456, signed -> rdata 0xFFFFFFF0; same with req_unsigned=1 -> 0x000000F0.
- Load half, mem_rdata 0x80017FFF: addr 0x2 signed -> 0xFFFF8001; addr 0x0 -> 0x00007FFF; word load addr 0x4 -> 0x80017FFF; ready in first WAIT cycle -> resp_valid exactly 3 cycles after accept.
- Word addr 0x6, and size 11 at addr 0x0 -> mem_en never high, resp_valid + resp_err one cycle after accept, rdata 0.
- TIMEOUT=8, mem_ready held 0 -> resp_err after exactly 8 WAIT cycles; mem_ready pulsed afterwards -> no extra response; ready on the 8th WAIT cycle -> err 0.
- Reset during WAIT -> no resp_valid, mem_en 0, req_ready 1 the cycle after reset drops; a following load completes normally.
